ingress_ram_loader: RTL and testbench

- Parametrised successor to the per-port packet-RAM loading front end.
- Avalon-MM slave that accepts 32-bit words from the HPS and writes them into NUM_PORTS per-port input RAMs, keeping one write pointer per port.
- Generalised in port count, data width and RAM depth; adds back-to-back write support, full detection, a sticky overflow flag, per-port occupancy readback and registered control/status CSRs.
- Sits between the bus bridge and the input RAMs; drives the scheduler-facing enables.

---
 rtl/ingress_ram_loader_if.sv | 27 ++
 rtl/ingress_ram_loader.sv | 124 ++++++++++++
 tb/tb_ingress_ram_loader.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ingress_ram_loader_if.sv
// Avalon-MM slave bundle between the HPS bus bridge and the ingress RAM loader.
interface ingress_ram_loader_if;
  logic        chipselect;
  logic        write;
  logic        read;
  logic [3:0]  address;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output chipselect,
    output write,
    output read,
    output address,
    output writedata,
    input  readdata
  );

  modport slave (
    input  chipselect,
    input  write,
    input  read,
    input  address,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/ingress_ram_loader.sv
// Ingress RAM loader: Avalon-MM slave that streams HPS words into per-port input
// RAMs with one write pointer per port, full/overflow tracking and control/status CSRs.
module ingress_ram_loader #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 12
) (
  input  logic                          clk,
  input  logic                          reset,
  ingress_ram_loader_if.slave           bus,
  output logic [DATA_W-1:0]             ram_wdata,
  output logic [NUM_PORTS-1:0]          ram_wren,
  output logic [NUM_PORTS*ADDR_W-1:0]   ram_wraddr,
  output logic                          write_enable,
  output logic                          read_enable,
  output logic                          reset_rams,
  output logic [NUM_PORTS-1:0]          overflow
);

  localparam int unsigned CNT_W      = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [3:0] NUM_PORTS_A = 4'(NUM_PORTS);
  localparam logic [3:0] ADDR_STOP   = 4'd12;
  localparam logic [3:0] ADDR_CLEAR  = 4'd13;
  localparam logic [3:0] ADDR_RDEN   = 4'd14;
  localparam logic [3:0] ADDR_WREN   = 4'd15;

  logic [CNT_W-1:0]     cnt_q [NUM_PORTS];
  logic [NUM_PORTS-1:0] wren_q;
  logic [31:0]          readdata_q;

  logic                 wr_acc;
  logic                 rd_acc;
  logic                 clear;
  logic [NUM_PORTS-1:0] sel_oh;
  logic [NUM_PORTS-1:0] issue;
  logic [NUM_PORTS-1:0] ovf_set;
  logic [NUM_PORTS-1:0] full;
  logic [CNT_W-1:0]     eff_cnt [NUM_PORTS];
  logic [31:0]          rd_next;

  // Access decode and per-port full check; the effective count folds in a RAM
  // write issued this cycle whose pointer increment lands at the end of it.
  always_comb begin
    wr_acc  = bus.chipselect && bus.write;
    rd_acc  = bus.chipselect && bus.read;
    clear   = wr_acc && (bus.address == ADDR_CLEAR);
    sel_oh  = '0;
    issue   = '0;
    ovf_set = '0;
    full    = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      sel_oh[p]  = wr_acc && (bus.address == 4'(p)) && (bus.address < NUM_PORTS_A);
      eff_cnt[p] = cnt_q[p] + CNT_W'(wren_q[p]);
      issue[p]   = sel_oh[p] && (eff_cnt[p] != DEPTH);
      ovf_set[p] = sel_oh[p] && (eff_cnt[p] == DEPTH);
      full[p]    = (cnt_q[p] == DEPTH);
    end
  end

  // Read mux: per-port occupancy words and the status word.
  always_comb begin
    rd_next = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (bus.address == 4'(p)) begin
        rd_next     = 32'(cnt_q[p]);
        rd_next[31] = overflow[p];
      end
    end
    if (bus.address == ADDR_STOP) begin
      rd_next     = 32'(full);
      rd_next[31] = write_enable;
      rd_next[30] = read_enable;
    end
  end

  // Pointer/count, overflow, control CSRs, RAM write stage and read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      wren_q       <= '0;
      ram_wdata    <= '0;
      reset_rams   <= 1'b0;
      overflow     <= '0;
      write_enable <= 1'b0;
      read_enable  <= 1'b0;
      readdata_q   <= '0;
      for (int p = 0; p < NUM_PORTS; p++) cnt_q[p] <= '0;
    end else begin
      wren_q     <= issue;
      reset_rams <= clear;
      if (|sel_oh) ram_wdata <= bus.writedata[DATA_W-1:0];
      if (clear) begin
        overflow <= '0;
        for (int p = 0; p < NUM_PORTS; p++) cnt_q[p] <= '0;
      end else begin
        overflow <= overflow | ovf_set;
        for (int p = 0; p < NUM_PORTS; p++) cnt_q[p] <= cnt_q[p] + CNT_W'(wren_q[p]);
      end
      if (wr_acc) begin
        case (bus.address)
          ADDR_STOP: begin
            write_enable <= 1'b0;
            read_enable  <= 1'b0;
          end
          ADDR_RDEN: read_enable  <= 1'b1;
          ADDR_WREN: write_enable <= 1'b1;
          default:   ;
        endcase
      end
      if (rd_acc) readdata_q <= rd_next;
    end
  end

  // A RAM write staged in the previous cycle is cancelled by reset in this one.
  always_comb begin
    ram_wren = wren_q & {NUM_PORTS{~reset}};
    for (int p = 0; p < NUM_PORTS; p++) begin
      ram_wraddr[p*ADDR_W +: ADDR_W] = cnt_q[p][ADDR_W-1:0];
    end
  end

  assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_ingress_ram_loader.sv
// Scoreboard bench for ingress_ram_loader with a 4-deep RAM per port.
module tb_ingress_ram_loader;
  localparam int NP = 4;
  localparam int DW = 32;
  localparam int AW = 2;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [DW-1:0]    ram_wdata;
  logic [NP-1:0]    ram_wren;
  logic [NP*AW-1:0] ram_wraddr;
  logic write_enable, read_enable, reset_rams;
  logic [NP-1:0]    overflow;

  ingress_ram_loader_if bus ();

  ingress_ram_loader #(.NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .ram_wdata    (ram_wdata),
    .ram_wren     (ram_wren),
    .ram_wraddr   (ram_wraddr),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .reset_rams   (reset_rams),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  port;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_exp_t;

  wr_exp_t     wr_q[$];
  logic [31:0] rd_q[$];
  int total = 0;
  int bad   = 0;

  // reference model
  int cnt_m [NP];
  bit ovf_m [NP];
  bit we_m, re_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] status_m();
    logic [31:0] s;
    s = '0;
    for (int p = 0; p < NP; p++) s[p] = (cnt_m[p] == DEPTH);
    s[31] = we_m;
    s[30] = re_m;
    return s;
  endfunction

  function automatic logic [31:0] port_word_m(input int p);
    logic [31:0] w;
    w = 32'(cnt_m[p]);
    w[31] = ovf_m[p];
    return w;
  endfunction

  task automatic model_clear();
    for (int p = 0; p < NP; p++) begin
      cnt_m[p] = 0;
      ovf_m[p] = 1'b0;
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.read       = 1'b0;
  endtask

  task automatic wr(input int addr, input logic [31:0] data);
    @(posedge clk); #1;
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.read       = 1'b0;
    bus.address    = 4'(addr);
    bus.writedata  = data;
    if (addr < NP) begin
      if (cnt_m[addr] < DEPTH) begin
        wr_q.push_back('{port: 4'(addr), addr: 32'(cnt_m[addr]), data: data});
        cnt_m[addr]++;
      end else begin
        ovf_m[addr] = 1'b1;
      end
    end else if (addr == 12) begin
      we_m = 1'b0;
      re_m = 1'b0;
    end else if (addr == 13) begin
      model_clear();
    end else if (addr == 14) begin
      re_m = 1'b1;
    end else if (addr == 15) begin
      we_m = 1'b1;
    end
  endtask

  // One idle cycle first so any in-flight pointer increment has settled.
  task automatic rd(input int addr);
    idle();
    @(posedge clk); #1;
    bus.chipselect = 1'b1;
    bus.write      = 1'b0;
    bus.read       = 1'b1;
    bus.address    = 4'(addr);
    if (addr < NP)       rd_q.push_back(port_word_m(addr));
    else if (addr == 12) rd_q.push_back(status_m());
    else                 rd_q.push_back(32'h0);
    idle();
  endtask

  // Output monitor: compares RAM writes and read data against the scoreboard.
  bit rd_armed = 1'b0;
  always @(negedge clk) begin
    if (rd_armed) begin
      if (rd_q.size() == 0) check("rd_unexpected", 32'(rd_q.size()), 32'd1);
      else check("readdata", bus.readdata, rd_q.pop_front());
    end
    rd_armed = bus.chipselect && bus.read && !reset;
    if (ram_wren != '0) begin
      if (wr_q.size() == 0) begin
        check("wren_unexpected", 32'(ram_wren), 32'h0);
      end else begin
        wr_exp_t e;
        logic [NP*AW-1:0] sh;
        e  = wr_q.pop_front();
        sh = ram_wraddr >> (int'(e.port) * AW);
        check("wren_onehot", 32'(ram_wren), 32'(1) << e.port);
        check("wraddr", 32'(sh[AW-1:0]), e.addr);
        check("wdata", ram_wdata, e.data);
      end
    end
  end

  initial begin
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.read       = 1'b0;
    bus.address    = '0;
    bus.writedata  = '0;
    model_clear();
    we_m = 1'b0;
    re_m = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_wren", 32'(ram_wren), 32'h0);
    check("rst_wraddr", 32'(ram_wraddr), 32'h0);
    check("rst_flags", {28'h0, write_enable, read_enable, reset_rams, 1'b0}, 32'h0);
    check("rst_ovf", 32'(overflow), 32'h0);
    check("rst_readdata", bus.readdata, 32'h0);

    // back-to-back writes to port 1
    wr(1, 32'hA5A5_0001);
    wr(1, 32'hA5A5_0002);
    wr(1, 32'hA5A5_0003);
    rd(1);

    // interleaved writes after a clear
    wr(13, 32'h0);
    wr(0, 32'h1111_0000);
    wr(3, 32'h3333_0000);
    wr(0, 32'h1111_0001);
    rd(0); rd(1); rd(2); rd(3);

    // fill and overflow port 2
    wr(13, 32'h0);
    for (int i = 0; i < 5; i++) wr(2, 32'h2222_0000 + 32'(i));
    rd(2);
    rd(12);
    @(negedge clk);
    check("ovf_port2", 32'(overflow), 32'h4);

    // write immediately followed by clear
    wr(13, 32'h0);
    wr(0, 32'hC0DE_0000);
    wr(13, 32'h0);
    idle();
    @(negedge clk);
    check("reset_rams_pulse", 32'(reset_rams), 32'h1);
    idle();
    @(negedge clk);
    check("reset_rams_end", 32'(reset_rams), 32'h0);
    rd(0);
    @(negedge clk);
    check("ovf_cleared", 32'(overflow), 32'h0);

    // control CSRs
    wr(15, 32'h0); rd(12);
    @(negedge clk);
    check("write_enable", 32'(write_enable), 32'(we_m));
    wr(14, 32'h0); rd(12);
    @(negedge clk);
    check("read_enable", 32'(read_enable), 32'(re_m));
    wr(12, 32'h0); rd(12);
    rd(9);

    // reset right after a data write
    wr(15, 32'h0);
    wr(3, 32'hAAAA_0000);
    wr(1, 32'hDEAD_BEEF);
    @(posedge clk); #1;
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    reset          = 1'b1;
    @(negedge clk);
    check("rst_cancel_wren", 32'(ram_wren), 32'h0);
    check("rst_dropped", 32'(wr_q.size()), 32'h1);
    wr_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    model_clear();
    we_m = 1'b0;
    re_m = 1'b0;
    @(negedge clk);
    check("rst2_flags", {29'h0, write_enable, read_enable, reset_rams}, 32'h0);
    check("rst2_wraddr", 32'(ram_wraddr), 32'h0);
    check("rst2_readdata", bus.readdata, 32'h0);
    rd(1); rd(3);

    repeat (4) idle();
    check("wr_q_drained", 32'(wr_q.size()), 32'h0);
    check("rd_q_drained", 32'(rd_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
